// File: rtl/cla_pkg.sv
// cla_pkg: shared constants for the carry-lookahead adder
package cla_pkg;
    localparam int CLA_GROUP = 4;
    localparam int CLA_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/cla_adder_lcu4.sv
// cla_lcu4: 4-bit lookahead unit producing flattened carries and group G/P
module cla_lcu4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       ci,
    output logic [3:1] c,
    output logic       gg,
    output logic       pg
);
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pg   = &p;
endmodule

// File: rtl/cla_adder.sv
// cla_adder: registered two-level carry-lookahead adder; CLA_OVERFLOW_EN adds signed-overflow output ovf
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             pg,
    output logic             gg
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int NG = WIDTH / CLA_GROUP;
    localparam int NS = (NG + CLA_GROUP - 1) / CLA_GROUP;
    if (WIDTH < CLA_GROUP || WIDTH % CLA_GROUP != 0) begin : g_bad_width
        $error("cla_adder: WIDTH must be a positive multiple of 4");
    end
    logic [WIDTH-1:0]    g, p, c;
    logic [NS*4-1:0]     grp_g, grp_p, gc;
    logic [NS-1:0]       sup_g, sup_p;
    logic [NS:0]         sc;
    logic                g_all;
    logic                unused_carries;
    assign g = a & b;
    assign p = a ^ b;
    for (genvar i = 0; i < NG; i++) begin : g_lvl1
        cla_lcu4 u_lcu (.g(g[4*i +: 4]), .p(p[4*i +: 4]), .ci(gc[i]), .c(c[4*i+1 +: 3]), .gg(grp_g[i]), .pg(grp_p[i]));
        assign c[4*i] = gc[i];
    end
    // Padding groups propagate so they are transparent to the upper level.
    for (genvar i = NG; i < NS*4; i++) begin : g_pad
        assign grp_g[i] = 1'b0;
        assign grp_p[i] = 1'b1;
    end
    for (genvar k = 0; k < NS; k++) begin : g_lvl2
        cla_lcu4 u_lcu (.g(grp_g[4*k +: 4]), .p(grp_p[4*k +: 4]), .ci(sc[k]), .c(gc[4*k+1 +: 3]), .gg(sup_g[k]), .pg(sup_p[k]));
        assign gc[4*k] = sc[k];
    end
    assign unused_carries = ^gc;
    // Super-group carries and the cin=0 generate across the whole word.
    always_comb begin
        sc[0] = cin;
        g_all = 1'b0;
        for (int k = 0; k < NS; k++) begin
            sc[k+1] = sup_g[k] | (sup_p[k] & sc[k]);
            g_all   = sup_g[k] | (sup_p[k] & g_all);
        end
    end
    // Output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            pg   <= 1'b0;
            gg   <= 1'b0;
`ifdef CLA_OVERFLOW_EN
            ovf  <= 1'b0;
`endif
        end else begin
            sum  <= p ^ c;
            cout <= sc[NS];
            pg   <= &sup_p;
            gg   <= g_all;
`ifdef CLA_OVERFLOW_EN
            ovf  <= sc[NS] ^ c[WIDTH-1];
`endif
        end
    end
endmodule

// File: tb/tb_cla_adder.sv
// tb_cla_adder: self-checking bench for cla_adder at WIDTH=4 and WIDTH=16
module tb_cla_adder;
`ifdef CLA_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    typedef struct packed {
        logic        ovf;
        logic        gg;
        logic        pg;
        logic        cout;
        logic [15:0] sum;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  a4 = 4'hF, b4 = 4'hF, sum4;
    logic        cin4 = 1'b1, cout4, pg4, gg4, ovf4;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        cin16 = 1'b0, cout16, pg16, gg16, ovf16;
    int checks = 0;
    int failures = 0;
    bit live = 1'b0;
    res_t exp4, exp16;

    cla_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4), .pg(pg4), .gg(gg4)
`ifdef CLA_OVERFLOW_EN
        , .ovf(ovf4)
`endif
    );
    cla_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16),
        .sum(sum16), .cout(cout16), .pg(pg16), .gg(gg16)
`ifdef CLA_OVERFLOW_EN
        , .ovf(ovf16)
`endif
    );
`ifndef CLA_OVERFLOW_EN
    assign ovf4 = 1'b0;
    assign ovf16 = 1'b0;
`endif

    function automatic res_t model(int w, logic [15:0] a, logic [15:0] b, logic cin);
        res_t r;
        logic [16:0] t;
        logic [15:0] m;
        m = (w == 16) ? 16'hFFFF : 16'h000F;
        t = {1'b0, a & m} + {1'b0, b & m} + {16'b0, cin};
        r.sum = t[15:0] & m;
        r.cout = t[w];
        r.pg = ((a ^ b) & m) == m;
        r.ovf = OVF_EN && (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
        t = {1'b0, a & m} + {1'b0, b & m};
        r.gg = t[w];
        return r;
    endfunction

    always @(posedge clk) begin
        exp4  <= rst ? '0 : model(4, {12'b0, a4}, {12'b0, b4}, cin4);
        exp16 <= rst ? '0 : model(16, a16, b16, cin16);
        live  <= 1'b1;
    end

    task automatic cmp(string n, res_t got, res_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", n, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            cmp("model_w4", {ovf4, gg4, pg4, cout4, 12'b0, sum4}, exp4);
            cmp("model_w16", {ovf16, gg16, pg16, cout16, sum16}, exp16);
        end
    end

    task automatic lit(string n, logic r, logic [3:0] a, logic [3:0] b, logic c,
                       logic [4:0] cs, logic p, logic g);
        @(negedge clk);
        rst = r; a4 = a; b4 = b; cin4 = c;
        @(posedge clk);
        #1;
        checks++;
        if ({cout4, sum4} !== cs || pg4 !== p || gg4 !== g) begin
            failures++;
            $display("FAIL %s got cs=%h pg=%b gg=%b exp cs=%h pg=%b gg=%b", n, {cout4, sum4}, pg4, gg4, cs, p, g);
        end
    endtask

    task automatic lit_ovf(string n, logic [3:0] a, logic [3:0] b, logic c, logic [4:0] cs, logic o);
        @(negedge clk);
        rst = 1'b0; a4 = a; b4 = b; cin4 = c;
        @(posedge clk);
        #1;
        checks++;
        if ({cout4, sum4} !== cs || ovf4 !== o) begin
            failures++;
            $display("FAIL %s got cs=%h ovf=%b exp cs=%h ovf=%b", n, {cout4, sum4}, ovf4, cs, o);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({cout4, sum4, pg4, gg4, ovf4} !== 8'h00) begin
                failures++;
                $display("FAIL reset%0d got cs=%h pg=%b gg=%b ovf=%b exp all zero", i, {cout4, sum4}, pg4, gg4, ovf4);
            end
        end
        lit("a1_b6",    1'b0, 4'h1, 4'h6, 1'b0, 5'h07, 1'b0, 1'b0);
        lit("a2_b4_c1", 1'b0, 4'h2, 4'h4, 1'b1, 5'h07, 1'b0, 1'b0);
        lit("a3_b4",    1'b0, 4'h3, 4'h4, 1'b0, 5'h07, 1'b0, 1'b0);
        lit("a4_b7",    1'b0, 4'h4, 4'h7, 1'b0, 5'h0B, 1'b0, 1'b0);
        lit("a9_b3_c1", 1'b0, 4'h9, 4'h3, 1'b1, 5'h0D, 1'b0, 1'b0);
        lit("mid_rst",  1'b1, 4'h5, 4'h5, 1'b1, 5'h00, 1'b0, 1'b0);
        lit("aF_b0_c1", 1'b0, 4'hF, 4'h0, 1'b1, 5'h10, 1'b1, 1'b0);
        lit("aF_bF_c1", 1'b0, 4'hF, 4'hF, 1'b1, 5'h1F, 1'b0, 1'b1);
        lit("zero",     1'b0, 4'h0, 4'h0, 1'b0, 5'h00, 1'b0, 1'b0);
        lit("a8_b7_c1", 1'b0, 4'h8, 4'h7, 1'b1, 5'h10, 1'b1, 1'b0);
`ifdef CLA_OVERFLOW_EN
        lit_ovf("ovf_a7_b1", 4'h7, 4'h1, 1'b0, 5'h08, 1'b1);
        lit_ovf("ovf_a8_b8", 4'h8, 4'h8, 1'b0, 5'h10, 1'b1);
        lit_ovf("ovf_a3_b2", 4'h3, 4'h2, 1'b0, 5'h05, 1'b0);
`endif
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            {a4, b4, cin4} = 9'(i);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            cin16 = 1'($urandom);
        end
        a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
        @(negedge clk);
        a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            cin16 = 1'($urandom);
            {a4, b4, cin4} = 9'($urandom);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
